// File: rtl/inst_trace_buffer_pkg.sv
// inst_trace_buffer_pkg: class codes, trace entry layout, buffer modes and MIPS opcode/funct fields
package inst_trace_buffer_pkg;
  localparam logic [3:0] CLS_NOP = 4'd0, CLS_ALU = 4'd1, CLS_MULDIV = 4'd2, CLS_BRANCH = 4'd3,
                         CLS_JUMP = 4'd4, CLS_LOAD = 4'd5, CLS_STORE = 4'd6, CLS_PRIV = 4'd7,
                         CLS_UNKNOWN = 4'd15;
  localparam int MODE_STREAM = 0, MODE_RING = 1;
  localparam logic [31:0] INSTR_ERET = 32'h42000018;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07,
                         OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F,
                         OP_COP0 = 6'h10, OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23,
                         OP_LBU = 6'h24, OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04,
                         F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08, F_JALR = 6'h09,
                         F_MOVZ = 6'h0A, F_MOVN = 6'h0B, F_SYSCALL = 6'h0C, F_BREAK = 6'h0D,
                         F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13,
                         F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B,
                         F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23,
                         F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27,
                         F_SLT = 6'h2A, F_SLTU = 6'h2B;
  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;
  localparam logic [4:0] RS_MFC0 = 5'h00, RS_MTC0 = 5'h04;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  cls;
  } entry_t;
endpackage

// File: rtl/inst_trace_buffer_if.sv
// inst_trace_buffer_if: commit capture lanes and trace drain port
interface inst_trace_buffer_if #(
  parameter int NUM_SLOTS = 2,
  parameter int DEPTH = 16
);
  logic [NUM_SLOTS-1:0]    commit_valid;
  logic [32*NUM_SLOTS-1:0] commit_pc;
  logic [32*NUM_SLOTS-1:0] commit_instr;
  logic                    freeze;
  logic                    rd_valid;
  logic                    rd_ready;
  logic [31:0]             rd_pc;
  logic [31:0]             rd_instr;
  logic [3:0]              rd_class;
  logic [$clog2(DEPTH):0]  count;
  logic [15:0]             drop_cnt;
  modport master (
    output commit_valid, commit_pc, commit_instr, freeze, rd_ready,
    input  rd_valid, rd_pc, rd_instr, rd_class, count, drop_cnt
  );
  modport slave (
    input  commit_valid, commit_pc, commit_instr, freeze, rd_ready,
    output rd_valid, rd_pc, rd_instr, rd_class, count, drop_cnt
  );
endinterface

// File: rtl/inst_trace_buffer_class_dec.sv
// inst_class_dec: combinational MIPS instruction word to trace class decoder
module inst_class_dec
  import inst_trace_buffer_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  cls
);
  logic [5:0] op, fn;
  logic [4:0] rs, rt;
  logic [3:0] r_cls, i_cls;
  assign op = instr[31:26];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign fn = instr[5:0];
  always_comb begin
    case (fn)
      F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_MOVZ, F_MOVN, F_MFHI, F_MTHI, F_MFLO, F_MTLO,
      F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: r_cls = CLS_ALU;
      F_MULT, F_MULTU, F_DIV, F_DIVU: r_cls = CLS_MULDIV;
      F_JR, F_JALR:                   r_cls = CLS_JUMP;
      F_SYSCALL, F_BREAK:             r_cls = CLS_PRIV;
      default:                        r_cls = CLS_UNKNOWN;
    endcase
    case (op)
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: i_cls = CLS_ALU;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: i_cls = CLS_BRANCH;
      OP_J, OP_JAL:                     i_cls = CLS_JUMP;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: i_cls = CLS_LOAD;
      OP_SB, OP_SH, OP_SW:              i_cls = CLS_STORE;
      OP_REGIMM: i_cls = (rt == RT_BLTZ || rt == RT_BGEZ || rt == RT_BLTZAL || rt == RT_BGEZAL) ? CLS_BRANCH : CLS_UNKNOWN;
      OP_COP0:   i_cls = (rs == RS_MFC0 || rs == RS_MTC0) ? CLS_PRIV : CLS_UNKNOWN;
      default:   i_cls = CLS_UNKNOWN;
    endcase
    cls = instr == INSTR_ERET ? CLS_PRIV : instr == '0 ? CLS_NOP : op == OP_RTYPE ? r_cls : i_cls;
  end
endmodule

// File: rtl/inst_trace_buffer.sv
// inst_trace_buffer: compacts committed lanes into a classified circular trace with a FWFT drain port
module inst_trace_buffer
  import inst_trace_buffer_pkg::*;
#(
  parameter int NUM_SLOTS = 2,
  parameter int DEPTH = 16,
  parameter int MODE = MODE_STREAM
) (
  input logic clk,
  input logic rst,
  inst_trace_buffer_if.slave t
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = PW + 2;
  entry_t mem [DEPTH];
  entry_t ent [NUM_SLOTS];
  logic [3:0] cls [NUM_SLOTS];
  logic [AW-1:0] pos [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] we;
  logic [AW-1:0] nv, space, excess, wr, occ;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [15:0] drop_cnt;
  logic [16:0] dsum;
  logic pop, rv;
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_lane
    inst_class_dec u_dec (.instr(t.commit_instr[32*g+:32]), .cls(cls[g]));
    assign ent[g] = '{pc: t.commit_pc[32*g+:32], instr: t.commit_instr[32*g+:32], cls: cls[g]};
  end
  assign rv = count != '0;
  assign pop = rv && t.rd_ready;
  // excess lanes are dropped in stream mode and overwrite the oldest entries in ring mode
  always_comb begin
    nv = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      pos[i] = nv;
      nv = nv + AW'(t.commit_valid[i] && !t.freeze);
    end
    space = AW'(DEPTH) - AW'(count) + AW'(pop);
    excess = nv > space ? nv - space : '0;
    wr = nv - ((MODE == MODE_RING) ? '0 : excess);
    for (int i = 0; i < NUM_SLOTS; i++)
      we[i] = t.commit_valid[i] && !t.freeze && ((MODE == MODE_RING) || pos[i] < space);
    occ = AW'(count) + wr - AW'(pop);
    dsum = {1'b0, drop_cnt} + 17'(excess);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      drop_cnt <= '0;
    end else begin
      head <= PW'(AW'(head) + AW'(pop) + ((MODE == MODE_RING) ? excess : '0));
      tail <= PW'(AW'(tail) + wr);
      count <= CW'(occ > AW'(DEPTH) ? AW'(DEPTH) : occ);
      drop_cnt <= dsum[16] ? 16'hFFFF : dsum[15:0];
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_SLOTS; i++)
      if (we[i]) mem[PW'(AW'(tail) + pos[i])] <= ent[i];
  assign t.rd_valid = rv;
  assign t.rd_pc = rv ? mem[head].pc : '0;
  assign t.rd_instr = rv ? mem[head].instr : '0;
  assign t.rd_class = rv ? mem[head].cls : '0;
  assign t.count = count;
  assign t.drop_cnt = drop_cnt;
endmodule

// File: tb/tb_inst_trace_buffer.sv
// tb_inst_trace_buffer: stream and ring instances driven in lockstep against queue scoreboards
module tb_inst_trace_buffer;
  import inst_trace_buffer_pkg::*;
  logic clk = 0, rst = 1, frz = 0, rdy = 0;
  logic [1:0] cv = '0;
  logic [63:0] cpc = '0, cins = '0;
  int checks = 0, fails = 0, d0 = 0, d1 = 0;
  entry_t q0[$], q1[$];
  inst_trace_buffer_if #(.NUM_SLOTS(2), .DEPTH(4)) ts ();
  inst_trace_buffer_if #(.NUM_SLOTS(2), .DEPTH(4)) tr ();
  assign ts.commit_valid = cv;
  assign ts.commit_pc = cpc;
  assign ts.commit_instr = cins;
  assign ts.freeze = frz;
  assign ts.rd_ready = rdy;
  assign tr.commit_valid = cv;
  assign tr.commit_pc = cpc;
  assign tr.commit_instr = cins;
  assign tr.freeze = frz;
  assign tr.rd_ready = rdy;
  inst_trace_buffer #(.NUM_SLOTS(2), .DEPTH(4), .MODE(MODE_STREAM)) u_s (.clk(clk), .rst(rst), .t(ts));
  inst_trace_buffer #(.NUM_SLOTS(2), .DEPTH(4), .MODE(MODE_RING)) u_r (.clk(clk), .rst(rst), .t(tr));
  always #5 clk = ~clk;

  function automatic entry_t ent(input logic [31:0] pc, input logic [31:0] ins, input logic [3:0] c);
    return '{pc: pc, instr: ins, cls: c};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    entry_t e0, e1;
    e0 = q0.size() != 0 ? q0[0] : '0;
    e1 = q1.size() != 0 ? q1[0] : '0;
    chk({ph, ".stream.rd_valid"}, 64'(ts.rd_valid), 64'(q0.size() != 0));
    chk({ph, ".stream.rd_pc"}, 64'(ts.rd_pc), 64'(e0.pc));
    chk({ph, ".stream.rd_instr"}, 64'(ts.rd_instr), 64'(e0.instr));
    chk({ph, ".stream.rd_class"}, 64'(ts.rd_class), 64'(e0.cls));
    chk({ph, ".stream.count"}, 64'(ts.count), 64'(q0.size()));
    chk({ph, ".stream.drop_cnt"}, 64'(ts.drop_cnt), 64'(d0));
    chk({ph, ".ring.rd_valid"}, 64'(tr.rd_valid), 64'(q1.size() != 0));
    chk({ph, ".ring.rd_pc"}, 64'(tr.rd_pc), 64'(e1.pc));
    chk({ph, ".ring.rd_instr"}, 64'(tr.rd_instr), 64'(e1.instr));
    chk({ph, ".ring.rd_class"}, 64'(tr.rd_class), 64'(e1.cls));
    chk({ph, ".ring.count"}, 64'(tr.count), 64'(q1.size()));
    chk({ph, ".ring.drop_cnt"}, 64'(tr.drop_cnt), 64'(d1));
  endtask

  task automatic cycle(input string ph, input logic [1:0] v, input entry_t l0, input entry_t l1,
                       input logic r, input logic f);
    entry_t ln[2];
    entry_t e;
    ln[0] = l0;
    ln[1] = l1;
    cv = v;
    cpc = {l1.pc, l0.pc};
    cins = {l1.instr, l0.instr};
    rdy = r;
    frz = f;
    @(posedge clk);
    if (r && q0.size() != 0) e = q0.pop_front();
    if (r && q1.size() != 0) e = q1.pop_front();
    if (!f)
      for (int i = 0; i < 2; i++)
        if (v[i]) begin
          if (q0.size() < 4) q0.push_back(ln[i]);
          else d0++;
          q1.push_back(ln[i]);
          if (q1.size() > 4) begin
            e = q1.pop_front();
            d1++;
          end
        end
    #1;
    cv = '0;
    check_all(ph);
  endtask

  task automatic do_reset(input string ph);
    @(negedge clk);
    rst = 1;
    q0.delete();
    q1.delete();
    d0 = 0;
    d1 = 0;
    #1;
    check_all({ph, ".async"});
    @(posedge clk);
    #1;
    rst = 0;
    check_all({ph, ".held"});
  endtask

  entry_t z, mix[14];
  initial begin
    z = '0;
    mix[0] = ent(32'h400, 32'h00851021, CLS_ALU);
    mix[1] = ent(32'h404, 32'h00850018, CLS_MULDIV);
    mix[2] = ent(32'h408, 32'h10850003, CLS_BRANCH);
    mix[3] = ent(32'h40C, 32'h0C000010, CLS_JUMP);
    mix[4] = ent(32'h410, 32'h03E00008, CLS_JUMP);
    mix[5] = ent(32'h414, 32'hAC850000, CLS_STORE);
    mix[6] = ent(32'h418, 32'h0000000C, CLS_PRIV);
    mix[7] = ent(32'h41C, 32'h40046000, CLS_PRIV);
    mix[8] = ent(32'h420, 32'hFC000000, CLS_UNKNOWN);
    mix[9] = ent(32'h424, 32'h3C011234, CLS_ALU);
    mix[10] = ent(32'h428, 32'h04810002, CLS_BRANCH);
    mix[11] = ent(32'h42C, 32'h04820002, CLS_UNKNOWN);
    mix[12] = ent(32'h430, 32'h00000001, CLS_UNKNOWN);
    mix[13] = ent(32'h434, 32'h8C880004, CLS_LOAD);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 0;
    cycle("nop_lw", 2'b11, ent(32'h100, 32'h0, CLS_NOP), ent(32'h104, 32'h8C880004, CLS_LOAD), 0, 0);
    cycle("nop_lw.pop1", 2'b00, z, z, 1, 0);
    cycle("nop_lw.pop2", 2'b00, z, z, 1, 0);
    cycle("empty_ready", 2'b00, z, z, 1, 0);
    do_reset("rst1");
    cycle("eret_lane1", 2'b10, ent(32'hDEAD, 32'h8C880004, CLS_LOAD), ent(32'h200, 32'h42000018, CLS_PRIV), 0, 0);
    cycle("eret_lane1.pop", 2'b00, z, z, 1, 0);
    for (int k = 0; k < 7; k++) begin
      cycle($sformatf("mix%0d", k), 2'b11, mix[2*k], mix[2*k+1], 1, 0);
      cycle($sformatf("mix%0d.drain", k), 2'b00, z, z, 1, 0);
    end
    cycle("mix.last", 2'b00, z, z, 1, 0);
    do_reset("rst2");
    for (int k = 0; k < 3; k++)
      cycle($sformatf("fill%0d", k), 2'b11, ent(32'h300 + 32'(8*k), 32'h00851021, CLS_ALU),
            ent(32'h304 + 32'(8*k), 32'h8C880004, CLS_LOAD), 0, 0);
    cycle("full_pop_push", 2'b01, ent(32'h318, 32'hAC850000, CLS_STORE), z, 1, 0);
    for (int k = 0; k < 5; k++)
      cycle($sformatf("freeze%0d", k), 2'b11, ent(32'h500, 32'h0, CLS_NOP), ent(32'h504, 32'h0, CLS_NOP), 0, 1);
    for (int k = 0; k < 5; k++) cycle($sformatf("drain%0d", k), 2'b00, z, z, 1, 0);
    cycle("refill", 2'b11, ent(32'h600, 32'h10850003, CLS_BRANCH), ent(32'h604, 32'h0C000010, CLS_JUMP), 0, 0);
    cycle("refill2", 2'b11, ent(32'h608, 32'h42000018, CLS_PRIV), ent(32'h60C, 32'hFC000000, CLS_UNKNOWN), 0, 0);
    do_reset("rst_mid");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
